// File: rtl/mem_responder.sv
// mem_responder
// Bridges a 32-bit word-oriented memory controller to an external 16-bit
// asynchronous SRAM. Each word access is split into a low half-word and a
// high half-word. The read and write strobes are stretched by WAIT_CYCLES
// extra clocks.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   addr            32-bit word address from the controller
//   fromCPU         write data, valid while wRAM is high
//   wRAM            write request level, held by the controller until saverdy
//   readstart       one-cycle read request pulse (addr valid in that cycle only)
//   toCPU           read data word
//   readrdy         one-cycle pulse, toCPU valid
//   saverdy         one-cycle pulse, write complete
//   overrun         sticky flag, a read request arrived while busy
//   sram_addr       half-word address to the SRAM
//   sram_dq_out     write data to the SRAM
//   sram_dq_in      read data from the SRAM
//   sram_dq_oe      drive enable for the external tristate buffer
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
module mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] addr,
    input  logic [31:0] fromCPU,
    input  logic        wRAM,
    input  logic        readstart,
    output logic [31:0] toCPU,
    output logic        readrdy,
    output logic        saverdy,
    output logic        overrun,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, RDY, WR_LO, WR_HI, WDONE
    } state_t;

    // Last phase-counter value of a read half, of a write half, and of the
    // write-enable strobe window inside a write half.
    localparam logic [4:0] RD_LAST     = 5'(WAIT_CYCLES);
    localparam logic [4:0] WR_LAST     = 5'(WAIT_CYCLES + 2);
    localparam logic [4:0] STROBE_LAST = 5'(WAIT_CYCLES + 1);

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic [14:0] addr_l, addr_l_next;
    logic [31:0] data_l, data_l_next;

    logic [31:0] to_cpu_next;
    logic        readrdy_next, saverdy_next, overrun_next;
    logic [15:0] sram_addr_next, sram_dq_out_next;
    logic        dq_oe_next, ce_n_next, oe_n_next, we_n_next;

    // State, latches and every output are registered together, so the
    // SRAM pins change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_l      <= '0;
            data_l      <= '0;
            toCPU       <= '0;
            readrdy     <= 1'b0;
            saverdy     <= 1'b0;
            overrun     <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            addr_l      <= addr_l_next;
            data_l      <= data_l_next;
            toCPU       <= to_cpu_next;
            readrdy     <= readrdy_next;
            saverdy     <= saverdy_next;
            overrun     <= overrun_next;
            sram_addr   <= sram_addr_next;
            sram_dq_out <= sram_dq_out_next;
            sram_dq_oe  <= dq_oe_next;
            sram_ce_n   <= ce_n_next;
            sram_oe_n   <= oe_n_next;
            sram_we_n   <= we_n_next;
        end
    end

    // Next-state logic. A read beats a simultaneous write in IDLE. The write
    // is picked up later because the controller keeps wRAM asserted.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        addr_l_next = addr_l;
        data_l_next = data_l;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (readstart) begin
                    state_next  = RD_LO;
                    addr_l_next = addr;
                end else if (wRAM) begin
                    state_next  = WR_LO;
                    addr_l_next = addr;
                    data_l_next = fromCPU;
                end
            end
            RD_LO, RD_HI: begin
                if (cnt == RD_LAST) begin
                    state_next = (state == RD_LO) ? RD_HI : RDY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            RDY: state_next = IDLE;
            WR_LO, WR_HI: begin
                if (cnt == WR_LAST) begin
                    state_next = (state == WR_LO) ? WR_HI : WDONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            WDONE: begin
                // Wait for wRAM to drop so a held request is not taken twice.
                if (!wRAM) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic. Each output is computed from the state and counter the
    // design moves into, so the registered outputs line up with that state.
    // toCPU captures the SRAM data on the last edge of each read half.
    always_comb begin
        to_cpu_next      = toCPU;
        sram_addr_next   = sram_addr;
        sram_dq_out_next = sram_dq_out;
        dq_oe_next       = 1'b0;
        ce_n_next        = 1'b1;
        oe_n_next        = 1'b1;
        we_n_next        = 1'b1;
        readrdy_next     = (state_next == RDY);
        saverdy_next     = (state_next == WDONE) && (state != WDONE);
        overrun_next     = overrun | (readstart && (state != IDLE));

        if (state == RD_LO && cnt == RD_LAST) to_cpu_next[15:0]  = sram_dq_in;
        if (state == RD_HI && cnt == RD_LAST) to_cpu_next[31:16] = sram_dq_in;

        case (state_next)
            RD_LO, RD_HI: begin
                ce_n_next      = 1'b0;
                oe_n_next      = 1'b0;
                sram_addr_next = {addr_l_next, (state_next == RD_HI)};
            end
            WR_LO, WR_HI: begin
                ce_n_next        = 1'b0;
                dq_oe_next       = 1'b1;
                sram_addr_next   = {addr_l_next, (state_next == WR_HI)};
                sram_dq_out_next = (state_next == WR_HI) ? data_l_next[31:16]
                                                         : data_l_next[15:0];
                // First cycle is address/data setup, last cycle is hold.
                we_n_next = !((cnt_next >= 5'd1) && (cnt_next <= STROBE_LAST));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Self-checking bench for mem_responder. It runs the main instance with
// WAIT_CYCLES=2 on a behavioural 16-bit SRAM model, and a second instance
// with WAIT_CYCLES=0. Expected read and write results are queued when a
// request is issued and are popped by a monitor when readrdy/saverdy fire.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] addr;
    logic [31:0] fromCPU;
    logic        wRAM, readstart;
    logic [31:0] toCPU;
    logic        readrdy, saverdy, overrun;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [14:0] addr_w0;
    logic        readstart_w0;
    logic [31:0] toCPU_w0;
    logic        readrdy_w0, saverdy_w0, overrun_w0;
    logic [15:0] sram_addr_w0, sram_dq_out_w0, sram_dq_in_w0;
    logic        dq_oe_w0, ce_n_w0, oe_n_w0, we_n_w0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_lo_cnt = 0;
    int we_hi_cnt = 0;

    logic [15:0] mem [0:65535];

    typedef struct { logic [31:0] data; int due; } rd_exp_t;
    typedef struct { logic [14:0] a; logic [31:0] data; int due; } wr_exp_t;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t rd_e;
    wr_exp_t wr_e;

    mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU), .readrdy(readrdy),
        .saverdy(saverdy), .overrun(overrun), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .addr(addr_w0), .fromCPU(32'h0), .wRAM(1'b0),
        .readstart(readstart_w0), .toCPU(toCPU_w0), .readrdy(readrdy_w0),
        .saverdy(saverdy_w0), .overrun(overrun_w0), .sram_addr(sram_addr_w0),
        .sram_dq_out(sram_dq_out_w0), .sram_dq_in(sram_dq_in_w0),
        .sram_dq_oe(dq_oe_w0), .sram_ce_n(ce_n_w0),
        .sram_oe_n(oe_n_w0), .sram_we_n(we_n_w0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: combinational read, and a write on each clock with the
    // write strobe low. It also counts strobe cycles per half-word.
    assign sram_dq_in = mem[sram_addr];
    assign sram_dq_in_w0 = (sram_addr_w0 == 16'h0246) ? 16'hBEEF :
                           (sram_addr_w0 == 16'h0247) ? 16'hDEAD : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr] = sram_dq_out;
            if (sram_addr[0]) we_hi_cnt++;
            else              we_lo_cnt++;
        end
    end

    // Scoreboard monitor for completion pulses.
    always @(negedge clk) begin
        if (readrdy) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_readrdy cycle=%0d toCPU=%h", cyc, toCPU);
            end else begin
                rd_e = rd_q.pop_front();
                if (toCPU !== rd_e.data || cyc != rd_e.due) begin
                    errors++;
                    $display("[TB] FAIL read_result toCPU=%h cycle=%0d expected %h at cycle %0d",
                             toCPU, cyc, rd_e.data, rd_e.due);
                end
            end
        end
        if (saverdy) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_saverdy cycle=%0d", cyc);
            end else begin
                wr_e = wr_q.pop_front();
                if (mem[{wr_e.a, 1'b0}] !== wr_e.data[15:0] ||
                    mem[{wr_e.a, 1'b1}] !== wr_e.data[31:16] || cyc != wr_e.due) begin
                    errors++;
                    $display("[TB] FAIL write_result lo=%h hi=%h cycle=%0d expected %h at cycle %0d",
                             mem[{wr_e.a, 1'b0}], mem[{wr_e.a, 1'b1}], cyc, wr_e.data, wr_e.due);
                end
            end
        end
        if (readrdy && saverdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL pulse_overlap readrdy=1 saverdy=1 expected never both");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout pending reads=%0d writes=%0d expected 0",
                     rd_q.size(), wr_q.size());
            rd_q.delete();
            wr_q.delete();
        end
    endtask

    // Waits for saverdy and then releases wRAM the way the controller would.
    task automatic wait_saverdy(input int hold_extra);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (saverdy) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL saverdy_timeout saw=0 expected 1");
        end
        for (int i = 0; i < hold_extra; i++) begin
            tick();
            checks++;
            if (sram_ce_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL held_wram_ce ce_n=%b expected 1", sram_ce_n);
            end
        end
        tick();
        wRAM = 1'b0;
    endtask

    task automatic issue_read(input logic [14:0] a, input logic [31:0] expv);
        tick();
        addr = a;
        readstart = 1'b1;
        rd_q.push_back('{data: expv, due: cyc + 7});
        tick();
        readstart = 1'b0;
        checks++;
        if (sram_addr !== {a, 1'b0} || sram_oe_n !== 1'b0 || sram_ce_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_lo_pins addr=%h oe_n=%b ce_n=%b expected %h 0 0",
                     sram_addr, sram_oe_n, sram_ce_n, {a, 1'b0});
        end
    endtask

    task automatic issue_write(input logic [14:0] a, input logic [31:0] d);
        tick();
        addr = a;
        fromCPU = d;
        wRAM = 1'b1;
        wr_q.push_back('{a: a, data: d, due: cyc + 11});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = '0; fromCPU = '0; wRAM = 1'b0; readstart = 1'b0;
        addr_w0 = '0; readstart_w0 = 1'b0;
        repeat (3) tick();
        checks++;
        if ({toCPU, readrdy, saverdy, overrun} !== 35'h0) begin
            errors++;
            $display("[TB] FAIL reset_status got %h/%b%b%b expected 0", toCPU, readrdy, saverdy, overrun);
        end
        checks++;
        if (sram_addr !== 16'h0 || sram_dq_out !== 16'h0 || sram_dq_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bus addr=%h dq=%h oe=%b expected 0 0 0", sram_addr, sram_dq_out, sram_dq_oe);
        end
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b expected 111", {sram_ce_n, sram_oe_n, sram_we_n});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        mem[16'h0246] = 16'hBEEF;
        mem[16'h0247] = 16'hDEAD;
        issue_read(15'h0123, 32'hDEADBEEF);
        drain();
    endtask

    task automatic test_write();
        we_lo_cnt = 0;
        we_hi_cnt = 0;
        issue_write(15'h0010, 32'h12345678);
        wait_saverdy(0);
        drain();
        checks++;
        if (we_lo_cnt != 3 || we_hi_cnt != 3) begin
            errors++;
            $display("[TB] FAIL we_strobe_len lo=%0d hi=%0d expected 3 3", we_lo_cnt, we_hi_cnt);
        end
    endtask

    task automatic test_held_write();
        issue_write(15'h0030, 32'hCAFEF00D);
        wait_saverdy(5);
        issue_read(15'h0123, 32'hDEADBEEF);
        drain();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_overrun got %b expected 0", overrun);
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFE] = 16'h1111;
        mem[16'hFFFF] = 16'h2222;
        issue_read(15'h7FFF, 32'h22221111);
        drain();
    endtask

    task automatic test_collision();
        issue_write(15'h0020, 32'hA5A55A5A);
        tick();
        tick();
        addr = 15'h0123;
        readstart = 1'b1;
        tick();
        readstart = 1'b0;
        addr = 15'h0020;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set got %b expected 1", overrun);
        end
        wait_saverdy(0);
        drain();
        // Simultaneous read and write: the read goes first and the write follows.
        tick();
        addr = 15'h0123;
        readstart = 1'b1;
        wRAM = 1'b1;
        fromCPU = 32'h0BADC0DE;
        rd_q.push_back('{data: 32'hDEADBEEF, due: cyc + 7});
        wr_q.push_back('{a: 15'h0040, data: 32'h0BADC0DE, due: cyc + 19});
        tick();
        readstart = 1'b0;
        addr = 15'h0040;
        wait_saverdy(0);
        drain();
    endtask

    task automatic test_reset_mid_write();
        issue_write(15'h0050, 32'h76543210);
        repeat (8) tick();
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 16'h00A1) begin
            errors++;
            $display("[TB] FAIL wr_hi_strobe we_n=%b addr=%h expected 0 00a1", sram_we_n, sram_addr);
        end
        rst = 1'b1;
        wRAM = 1'b0;
        wr_q.delete();
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1 ||
            sram_addr !== 16'h0 || overrun !== 1'b0 || toCPU !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_write we_n=%b oe=%b ce_n=%b addr=%h ovr=%b toCPU=%h expected 1 0 1 0 0 0",
                     sram_we_n, sram_dq_oe, sram_ce_n, sram_addr, overrun, toCPU);
        end
        tick();
        rst = 1'b0;
        issue_read(15'h0123, 32'hDEADBEEF);
        drain();
        repeat (15) tick();
    endtask

    task automatic test_wait0();
        bit seen = 0;
        int start;
        tick();
        addr_w0 = 15'h0123;
        readstart_w0 = 1'b1;
        start = cyc;
        tick();
        readstart_w0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (readrdy_w0) begin seen = 1; break; end
        end
        checks++;
        if (!seen || cyc != start + 3 || toCPU_w0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL wait0_read seen=%b cycle=%0d toCPU=%h expected 1 %0d deadbeef",
                     seen, cyc, toCPU_w0, start + 3);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_held_write();
        test_wrap();
        test_collision();
        test_reset_mid_write();
        test_wait0();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM strobe-extension cycles per half-word access (legal range 0..15).
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 addr  in  15  32-bit word address from memory controller.
REQ-005 fromCPU  in  32  write data; valid while wRAM=1.
REQ-006 wRAM  in  1  write request level; held by controller until saverdy.
REQ-007 readstart  in  1  one-cycle read request pulse; addr valid only in that cycle.
REQ-008 toCPU  out  32  read data word.
REQ-009 readrdy  out  1  one-cycle pulse: toCPU valid.
REQ-010 saverdy  out  1  one-cycle pulse: write complete.
REQ-011 overrun  out  1  sticky: readstart arrived while busy.
REQ-012 sram_addr  out  16  half-word address to external 16-bit SRAM.
REQ-013 sram_dq_out  out  16  write data to SRAM.
REQ-014 sram_dq_in  in  16  read data from SRAM.
REQ-015 sram_dq_oe  out  1  drive enable for external tristate buffer.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States: IDLE, RD_LO, RD_HI, RDY, WR_LO, WR_HI, WDONE.
- Phase counter 0..WAIT_CYCLES+2.
REQ-019 IDLE behaviour:
- readstart=1: latch addr, go RD_LO.
- else wRAM=1: latch addr and fromCPU, go WR_LO.
- Both asserted: read wins; write starts after RDY, because wRAM is still held.
REQ-020 Read phase (RD_LO, RD_HI): WAIT_CYCLES+1 cycles each.
- sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0.
- sram_addr={addr_latched,0} in RD_LO, {addr_latched,1} in RD_HI.
- sram_dq_in sampled at the final edge of each phase into toCPU[15:0] / toCPU[31:16].
REQ-021 RDY: readrdy=1 for exactly one cycle, then go IDLE.
- toCPU holds its value until the next read's RD_LO sample.
REQ-022 Read latency: readstart in cycle 0 -> readrdy in cycle 2*(WAIT_CYCLES+1)+1 (cycle 7 at default).
REQ-023 Write phase (WR_LO, WR_HI): WAIT_CYCLES+3 cycles each.
- sram_dq_oe=1 and sram_ce_n=0 throughout.
- Cycle 0 setup: sram_we_n=1.
- Cycles 1..WAIT_CYCLES+1 strobe: sram_we_n=0.
- Last cycle hold: sram_we_n=1.
- sram_addr and sram_dq_out stable across the whole phase.
- WR_LO drives data[15:0] to {addr,0}; WR_HI drives data[31:16] to {addr,1}.
REQ-024 WDONE: saverdy=1 in the first WDONE cycle only.
- Remain in WDONE until wRAM=0, then go IDLE; prevents a held wRAM from being taken as a second write.
REQ-025 Write latency: wRAM sampled in cycle 0 -> saverdy in cycle 2*(WAIT_CYCLES+3)+1 (cycle 11 at default).
REQ-026 Request while busy:
- readstart in any non-IDLE state SHALL be ignored and SHALL set overrun=1.
- wRAM in RD_* or RDY is deferred, not an error.
REQ-027 readrdy and saverdy SHALL never be asserted in the same cycle.
REQ-028 When not accessing SRAM: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
REQ-029 addr wrap: addr=15'h7FFF SHALL produce sram_addr 16'hFFFE then 16'hFFFF, with no overflow into other bits.

Reset
REQ-030 rst=1 SHALL immediately force the following, regardless of state (including mid-write):
- state IDLE, counter 0.
- toCPU=0, readrdy=0, saverdy=0, overrun=0.
- sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all SRAM strobes 1.
REQ-031 A write interrupted by reset SHALL NOT be resumed; the controller reissues it.

Verification
REQ-032 Read: SRAM model holds [0x0246]=0xBEEF, [0x0247]=0xDEAD; readstart with addr=0x0123 -> readrdy pulse in cycle 7, toCPU=0xDEADBEEF.
REQ-033 Write: wRAM=1, addr=0x0010, fromCPU=0x12345678 -> SRAM[0x0020]=0x5678, SRAM[0x0021]=0x1234; saverdy in cycle 11; sram_we_n low exactly 3 cycles per half.
REQ-034 Held wRAM: keep wRAM=1 for 5 cycles after saverdy -> no second write and no second saverdy; IDLE one cycle after wRAM falls.
REQ-035 Collision: readstart during WR_LO -> overrun=1, write completes normally, no readrdy; simultaneous readstart+wRAM in IDLE -> read first, then write.
REQ-036 Reset mid-operation: rst pulse in WR_HI strobe cycle -> sram_we_n=1 and sram_dq_oe=0 in the same cycle, all outputs at reset values; next readstart served normally. Repeat REQ-032 with WAIT_CYCLES=0 -> readrdy in cycle 3.
